// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
// Used by icache_tag_store and icache_direct_mapped.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    FILL     = 2'd2
  } state_e;

  localparam int BLOCK_OFFSET_W  = 4;
  localparam int WORD_SEL_W      = 2;
  localparam int MEM_ADDR_W      = 28;
  localparam int BLOCK_W         = 128;
  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int STAT_W          = 16;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
    if (value == {STAT_W{1'b1}}) begin
      return value;
    end
    return value + 1'b1;
  endfunction

endpackage

// File: rtl/icache_tag_store.sv
// Valid bits and tags for every cache line plus the hit comparator.
// Lookup and refill share one idx/tag pair because the CPU holds its address during a miss.
module icache_tag_store
  import icache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int IDX_W      = 3,
  parameter int TAG_W      = 25
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             wr_en_i,
  output logic             hit_o
);

  logic             valid_q [NUM_BLOCKS];
  logic [TAG_W-1:0] tag_q   [NUM_BLOCKS];

  // Valid bits are the only state that must clear on reset; tags are don't-care while invalid.
  for (genvar gi = 0; gi < NUM_BLOCKS; gi++) begin : g_valid
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        valid_q[gi] <= 1'b0;
      end else if (wr_en_i && (idx_i == IDX_W'(gi))) begin
        valid_q[gi] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      tag_q[idx_i] <= tag_i;
    end
  end

  assign hit_o = valid_q[idx_i] && (tag_q[idx_i] == tag_i);

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped, read-only instruction cache that refills whole 16-byte blocks from a streaming memory.
// Define ICACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module icache_direct_mapped
  import icache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int ADDR_W     = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read,
  input  logic [ADDR_W-1:0]     address,
  output logic [WORD_W-1:0]     instruction,
  output logic                  busywait,
  output logic                  mem_read,
  output logic [MEM_ADDR_W-1:0] mem_address,
  input  logic [BLOCK_W-1:0]    mem_readdata,
  input  logic                  mem_busywait
`ifdef ICACHE_STATS_EN
  ,
  output logic [STAT_W-1:0]     hit_count,
  output logic [STAT_W-1:0]     miss_count
`endif
);

  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W = ADDR_W - BLOCK_OFFSET_W - IDX_W;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic [WORD_SEL_W-1:0] word_sel;
  logic                  hit;
  logic                  fill_we;
  logic                  unused_addr_bits;

  assign idx              = address[BLOCK_OFFSET_W +: IDX_W];
  assign tag              = address[ADDR_W-1 -: TAG_W];
  assign word_sel         = address[2 +: WORD_SEL_W];
  assign mem_address      = address[BLOCK_OFFSET_W +: MEM_ADDR_W];
  assign unused_addr_bits = ^address[1:0];
  assign fill_we          = (state_q == FILL);

  icache_tag_store #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .IDX_W      (IDX_W),
    .TAG_W      (TAG_W)
  ) u_tag_store (
    .clock   (clock),
    .reset   (reset),
    .idx_i   (idx),
    .tag_i   (tag),
    .wr_en_i (fill_we),
    .hit_o   (hit)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (read && !hit) state_d = MEM_READ;
      MEM_READ: if (!mem_busywait) state_d = FILL;
      FILL:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // The reset term keeps the CPU un-stalled while reset is held, even with read asserted on empty lines.
  always_comb begin
    busywait = 1'b0;
    mem_read = 1'b0;
    unique case (state_q)
      IDLE:     busywait = read && !hit && !reset;
      MEM_READ: begin
        busywait = 1'b1;
        mem_read = 1'b1;
      end
      FILL:     busywait = 1'b1;
      default:  busywait = 1'b0;
    endcase
  end

  logic [BLOCK_W-1:0] data_q [NUM_BLOCKS];
  logic [BLOCK_W-1:0] line;
  logic [WORD_W-1:0]  line_words [WORDS_PER_BLOCK];

  always_ff @(posedge clock) begin
    if (fill_we) begin
      data_q[idx] <= mem_readdata;
    end
  end

  assign line = data_q[idx];

  for (genvar gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_word
    assign line_words[gi] = line[gi*WORD_W +: WORD_W];
  end

  assign instruction = line_words[word_sel];

`ifdef ICACHE_STATS_EN
  logic [STAT_W-1:0] hit_count_q, miss_count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if ((state_q == IDLE) && read && hit) begin
        hit_count_q <= sat_inc(hit_count_q);
      end
      if ((state_q == IDLE) && (state_d == MEM_READ)) begin
        miss_count_q <= sat_inc(miss_count_q);
      end
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed bench for icache_direct_mapped against a 16-cycle byte-serial instruction memory.
// Counter checks are included when ICACHE_STATS_EN is defined.
module tb_icache_direct_mapped;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         read = 1'b0;
  logic [31:0]  address = '0;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_rdata = '0;
  logic         mem_busywait;
`ifdef ICACHE_STATS_EN
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;
`endif

  int checks = 0;
  int passes = 0;

  always #5 clock = ~clock;

  icache_direct_mapped dut (
    .clock        (clock),
    .reset        (reset),
    .read         (read),
    .address      (address),
    .instruction  (instruction),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_rdata),
    .mem_busywait (mem_busywait)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  // Byte-serial memory: one byte per mem_read edge, busywait low during the 16th transfer cycle.
  logic [7:0] mem [256];
  logic [3:0] mem_cnt = '0;

  assign mem_busywait = (mem_cnt != 4'd15);

  always @(posedge clock) begin
    if (mem_read) begin
      mem_rdata[mem_cnt*8 +: 8] <= mem[{mem_address[3:0], mem_cnt}];
      mem_cnt <= mem_cnt + 4'd1;
    end else begin
      mem_cnt <= '0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a posedge; leaves one idle cycle after the fetch.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp_instr, input logic exp_miss);
    int   edges;
    logic seen;
    edges = 0;
    seen  = 1'b0;
    read    = 1'b1;
    address = addr;
    @(negedge clock);
    chk("req_busywait", {31'd0, busywait}, {31'd0, exp_miss});
    chk("req_mem_read", {31'd0, mem_read}, 32'd0);
    if (exp_miss) begin
      for (int e = 1; e <= 100; e++) begin
        @(posedge clock);
        @(negedge clock);
        if (mem_read && !seen) begin
          seen = 1'b1;
          chk("mem_address", {4'd0, mem_address}, addr >> 4);
        end
        if (!busywait) begin
          edges = e;
          break;
        end
      end
      chk("miss_edges", edges, 32'd18);
      chk("mem_read_seen", {31'd0, seen}, 32'd1);
    end
    chk("instruction", instruction, exp_instr);
    chk("done_busywait", {31'd0, busywait}, 32'd0);
    chk("done_mem_read", {31'd0, mem_read}, 32'd0);
    $display("fetch addr=%h instr=%h miss=%0d edges=%0d", addr, instruction, exp_miss, edges);
    @(posedge clock);
    #1;
    read = 1'b0;
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        miss;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int   wait_cnt;
    logic done;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    {mem[3],   mem[2],   mem[1],   mem[0]}   = 32'h3e800013;
    {mem[7],   mem[6],   mem[5],   mem[4]}   = 32'h00208093;
    {mem[19],  mem[18],  mem[17],  mem[16]}  = 32'h40100133;
    {mem[23],  mem[22],  mem[21],  mem[20]}  = 32'h87654321;
    {mem[131], mem[130], mem[129], mem[128]} = 32'h12345678;
    {mem[143], mem[142], mem[141], mem[140]} = 32'hdeadbeef;
    {mem[147], mem[146], mem[145], mem[144]} = 32'h0badf00d;

    vecs[0] = '{32'h00, 32'h3e800013, 1'b1};  // cold miss
    vecs[1] = '{32'h04, 32'h00208093, 1'b0};  // same line, word 1
    vecs[2] = '{32'h10, 32'h40100133, 1'b1};  // idx 1 refill
    vecs[3] = '{32'h00, 32'h3e800013, 1'b0};  // line 0 untouched
    vecs[4] = '{32'h80, 32'h12345678, 1'b1};  // conflict on idx 0
    vecs[5] = '{32'h00, 32'h3e800013, 1'b1};  // evicted, misses again
    vecs[6] = '{32'h14, 32'h87654321, 1'b0};  // idx 1 still valid
    vecs[7] = '{32'h8C, 32'hdeadbeef, 1'b1};  // conflict, word 3

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_busywait", {31'd0, busywait}, 32'd0);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
`ifdef ICACHE_STATS_EN
    chk("rst_hit_count", {16'd0, hit_count}, 32'd0);
    chk("rst_miss_count", {16'd0, miss_count}, 32'd0);
`endif
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;

    for (int i = 0; i < 8; i++) begin
      do_fetch(vecs[i].addr, vecs[i].instr, vecs[i].miss);
    end

    // read drops mid-refill: the fill still completes and the line then hits
    read    = 1'b1;
    address = 32'h90;
    @(negedge clock);
    chk("drop_req_busywait", {31'd0, busywait}, 32'd1);
    repeat (5) @(posedge clock);
    #1;
    read = 1'b0;
    @(negedge clock);
    chk("drop_busywait", {31'd0, busywait}, 32'd1);
    chk("drop_mem_read", {31'd0, mem_read}, 32'd1);
    done = 1'b0;
    for (wait_cnt = 0; wait_cnt < 40; wait_cnt++) begin
      @(negedge clock);
      if (!busywait) begin
        done = 1'b1;
        break;
      end
    end
    chk("drop_fill_done", {31'd0, done}, 32'd1);
    $display("dropped read addr=%h fill_done=%0d after %0d cycles", 32'h90, done, wait_cnt);
    @(posedge clock);
    #1;
    do_fetch(32'h90, 32'h0badf00d, 1'b0);

    // reset during MEM_READ with read still held
    read    = 1'b1;
    address = 32'h00;
    @(negedge clock);
    chk("rr_req_busywait", {31'd0, busywait}, 32'd1);
    repeat (5) @(posedge clock);
    #1;
    chk("rr_in_mem_read", {31'd0, mem_read}, 32'd1);
`ifdef ICACHE_STATS_EN
    chk("pre_rst_hit_count", {16'd0, hit_count}, 32'd9);
    chk("pre_rst_miss_count", {16'd0, miss_count}, 32'd7);
`endif
    reset = 1'b1;
    #1;
    chk("rr_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rr_busywait", {31'd0, busywait}, 32'd0);
`ifdef ICACHE_STATS_EN
    chk("rr_hit_count", {16'd0, hit_count}, 32'd0);
    chk("rr_miss_count", {16'd0, miss_count}, 32'd0);
`endif
    $display("reset mid-refill mem_read=%0d busywait=%0d", mem_read, busywait);
    @(posedge clock);
    #1;
    reset = 1'b0;
    read  = 1'b0;
    @(posedge clock);
    #1;
    do_fetch(32'h00, 32'h3e800013, 1'b1);
    do_fetch(32'h90, 32'h0badf00d, 1'b1);
`ifdef ICACHE_STATS_EN
    chk("end_hit_count", {16'd0, hit_count}, 32'd2);
    chk("end_miss_count", {16'd0, miss_count}, 32'd2);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
